// File: rtl/uart_receiver.sv
// Purpose: UART receiver, 8 data bits LSB first, inverted-XOR parity and one stop bit, all decisions on a 2-flop synchronised rx.
// Latency: data_valid one cycle after the mid-stop-bit sample, i.e. sync + edge + HALF + 10*CLKS_PER_BIT + 1 cycles after the rx fall.
// Backpressure: none; data_valid and frame_error are single-cycle pulses that the consumer must take when they occur.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  // Mid-bit offset measured from the detected start edge; never zero so the
  // start bit is always re-checked at least one cycle after the edge.
  localparam int HALF_RAW = CLKS_PER_BIT / 2;
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;

  // Terminal counts for the tick counter (counter starts at 0 the cycle after a clear).
  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);
  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Synchroniser and edge-detect history.
  logic       sync1_q,   sync1_d;
  logic       rx_s_q,    rx_s_d;
  logic       rx_prev_q, rx_prev_d;

  // Frame-tracking state.
  state_t     state_q,   state_d;
  logic [7:0] tick_q,    tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q,   shift_d;
  logic       rx_par_q,  rx_par_d;

  // Registered outputs.
  logic [7:0] data_out_q,     data_out_d;
  logic       data_valid_q,   data_valid_d;
  logic       parity_error_q, parity_error_d;
  logic       frame_error_q,  frame_error_d;
  logic       busy_q,         busy_d;

  // Decode helpers derived from the current state.
  logic       rx_fell;
  logic       half_hit;
  logic       bit_hit;
  logic       parity_bad;

  // Edge and sample-point decode; the edge uses rx_s against its previous value
  // so a start bit that lands on the first IDLE cycle is still caught.
  always_comb begin
    rx_fell    = rx_prev_q & ~rx_s_q;
    half_hit   = (tick_q == HALF_LAST);
    bit_hit    = (tick_q == BIT_LAST);
    parity_bad = (rx_par_q != ~(^shift_q));
  end

  // Next-state and next-output computation for the whole receiver.
  always_comb begin
    sync1_d        = rx;
    rx_s_d         = sync1_q;
    rx_prev_d      = rx_s_q;

    state_d        = state_q;
    tick_d         = tick_q + 8'd1;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_par_d       = rx_par_q;

    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d = 8'd0;
        if (rx_fell) begin
          state_d = START;
        end
      end

      START: begin
        if (half_hit) begin
          tick_d = 8'd0;
          if (!rx_s_q) begin
            // Start bit still low at mid-bit: a real frame.
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Line bounced back high: treat as a glitch, drop silently.
            state_d   = IDLE;
          end
        end
      end

      DATA: begin
        if (bit_hit) begin
          tick_d             = 8'd0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      PARITY: begin
        if (bit_hit) begin
          tick_d   = 8'd0;
          rx_par_d = rx_s_q;
          state_d  = STOP;
        end
      end

      STOP: begin
        if (bit_hit) begin
          tick_d = 8'd0;
          if (rx_s_q) begin
            // Good stop bit: publish the byte and its parity status.
            data_out_d     = shift_q;
            data_valid_d   = 1'b1;
            parity_error_d = parity_bad;
            state_d        = IDLE;
          end else begin
            // Stop bit low: flag it and wait out the break; byte is discarded.
            frame_error_d  = 1'b1;
            state_d        = BREAK;
          end
        end
      end

      BREAK: begin
        tick_d = 8'd0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        tick_d  = 8'd0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All receiver state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_prev_q      <= 1'b1;
      state_q        <= IDLE;
      tick_q         <= 8'd0;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_par_q       <= 1'b0;
      data_out_q     <= 8'h00;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      rx_s_q         <= rx_s_d;
      rx_prev_q      <= rx_prev_d;
      state_q        <= state_d;
      tick_q         <= tick_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_par_q       <= rx_par_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      busy_q         <= busy_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Purpose: randomized and directed bench for uart_receiver at 2 and 4 clocks per bit, checked against a frame-level model.
// Latency: not applicable; stimulus is bit-timed on the falling clock edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable; every output pulse is logged by a monitor and reconciled against the model.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx2, rx4;
  logic [7:0] d2, d4;
  logic       v2, v4, p2, p4, f2, f4, b2, b4;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .data_out(d2), .data_valid(v2),
    .parity_error(p2), .frame_error(f2), .busy(b2)
  );

  uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4), .data_out(d4), .data_valid(v4),
    .parity_error(p4), .frame_error(f4), .busy(b4)
  );

  // Observed events from each receiver.
  logic [7:0] o2_d[$], o4_d[$];
  logic       o2_p[$], o4_p[$];
  int         o2_c[$], o4_c[$];
  int         o2_fe = 0, o4_fe = 0, o2_both = 0, o4_both = 0;
  bit         b4_seen = 1'b0;

  // Frame-level reference model: expected valid bytes, their parity status and the cycle each frame started.
  logic [7:0] e2_d[$], e4_d[$];
  logic       e2_p[$], e4_p[$];
  int         e2_s[$], e4_s[$];
  int         e2_fe = 0, e4_fe = 0;
  logic [7:0] last_d[2];
  logic       last_p[2];

  always @(posedge clk) begin
    #1;
    if (v2) begin o2_d.push_back(d2); o2_p.push_back(p2); o2_c.push_back(cyc); end
    if (v4) begin o4_d.push_back(d4); o4_p.push_back(p4); o4_c.push_back(cyc); end
    if (f2) o2_fe++;
    if (f4) o4_fe++;
    if (v2 && f2) o2_both++;
    if (v4 && f4) o4_both++;
    if (b4) b4_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb(input bit sel4);
    return sel4 ? 4 : 2;
  endfunction

  // Hold the selected line at a level for a number of bit periods.
  task automatic line_hold(input bit sel4, input logic v, input int nbits);
    if (sel4) rx4 = v; else rx2 = v;
    repeat (nbits * cpb(sel4)) @(negedge clk);
  endtask

  // Send one frame and record what the link rules say must come out of it.
  task automatic send_frame(input bit sel4, input logic [7:0] data, input logic par, input logic stop);
    int  start;
    int  ones;
    logic perr;
    start = cyc;
    ones  = $countones(data);
    // Correct parity bit is 1 when the data has an even number of ones.
    perr  = (par != ((ones % 2) == 0));
    line_hold(sel4, 1'b0, 1);
    for (int i = 0; i < 8; i++) line_hold(sel4, data[i], 1);
    line_hold(sel4, par, 1);
    line_hold(sel4, stop, 1);
    if (stop) begin
      if (sel4) begin e4_d.push_back(data); e4_p.push_back(perr); e4_s.push_back(start); end
      else      begin e2_d.push_back(data); e2_p.push_back(perr); e2_s.push_back(start); end
      last_d[sel4] = data;
      last_p[sel4] = perr;
    end else begin
      if (sel4) e4_fe++; else e2_fe++;
    end
  endtask

  function automatic logic good_parity(input logic [7:0] data);
    return ($countones(data) % 2) == 0;
  endfunction

  // Reconcile everything observed on one receiver against the model, then clear both sides.
  task automatic check_results(input bit sel4, input string tag);
    logic [7:0] od[$], ed[$];
    logic       op[$], ep[$];
    int         oc[$], es[$];
    int         ofe, efe, obo, n, lat, lo, hi, c;
    logic [7:0] cur_d;
    logic       cur_p, cur_b;
    c = cpb(sel4);
    if (sel4) begin
      od = o4_d; op = o4_p; oc = o4_c; ofe = o4_fe; obo = o4_both;
      ed = e4_d; ep = e4_p; es = e4_s; efe = e4_fe;
      cur_d = d4; cur_p = p4; cur_b = b4;
      o4_d.delete(); o4_p.delete(); o4_c.delete(); o4_fe = 0; o4_both = 0;
      e4_d.delete(); e4_p.delete(); e4_s.delete(); e4_fe = 0;
    end else begin
      od = o2_d; op = o2_p; oc = o2_c; ofe = o2_fe; obo = o2_both;
      ed = e2_d; ep = e2_p; es = e2_s; efe = e2_fe;
      cur_d = d2; cur_p = p2; cur_b = b2;
      o2_d.delete(); o2_p.delete(); o2_c.delete(); o2_fe = 0; o2_both = 0;
      e2_d.delete(); e2_p.delete(); e2_s.delete(); e2_fe = 0;
    end
    chk({tag, "_nvalid"}, od.size(), ed.size());
    n = (od.size() < ed.size()) ? od.size() : ed.size();
    // Allowed start-fall to data_valid latency, with one cycle of slack for where the fall is counted from.
    hi = 4 + (c / 2) + 10 * c;
    lo = hi - 1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), od[i], ed[i]);
      chk($sformatf("%s_perr%0d", tag, i), op[i], ep[i]);
      lat = oc[i] - es[i];
      chk($sformatf("%s_lat%0d(%0d)", tag, i, lat), (lat >= lo && lat <= hi), 1);
    end
    chk({tag, "_nferr"}, ofe, efe);
    chk({tag, "_excl"}, obo, 0);
    chk({tag, "_dout_hold"}, cur_d, last_d[sel4]);
    chk({tag, "_perr_hold"}, cur_p, last_p[sel4]);
    chk({tag, "_busy_idle"}, cur_b, 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp, rs;
    int         gap;
    last_d[0] = 8'h00; last_d[1] = 8'h00;
    last_p[0] = 1'b0;  last_p[1] = 1'b0;
    rst_n = 1'b0;
    rx2 = 1'b1;
    rx4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout2", d2, 8'h00);
    chk("rst_valid2", v2, 1'b0);
    chk("rst_perr2", p2, 1'b0);
    chk("rst_ferr2", f2, 1'b0);
    chk("rst_busy2", b2, 1'b0);
    chk("rst_dout4", d4, 8'h00);
    chk("rst_busy4", b4, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean byte with correct parity.
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 3);
    check_results(1'b0, "t1_a5");

    // Bad parity, then good parity clears the flag; flag must hold in between.
    send_frame(1'b0, 8'h01, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 3);
    check_results(1'b0, "t2_01");
    line_hold(1'b0, 1'b1, 2);
    chk("t2_perr_still", p2, 1'b1);
    send_frame(1'b0, 8'h03, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 3);
    check_results(1'b0, "t2_03");

    // Framing error with the line held low as a break.
    send_frame(1'b0, 8'h3C, good_parity(8'h3C), 1'b0);
    line_hold(1'b0, 1'b0, 2);
    chk("t3_busy_break_a", b2, 1'b1);
    line_hold(1'b0, 1'b0, 3);
    chk("t3_busy_break_b", b2, 1'b1);
    line_hold(1'b0, 1'b1, 2);
    check_results(1'b0, "t3_3c");

    // Randomized frames, mostly well formed, some bad parity or stop.
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0) ? ~good_parity(rd) : good_parity(rd);
      rs = ($urandom_range(0, 4) != 0);
      send_frame(1'b0, rd, rp, rs);
      line_hold(1'b0, 1'b1, 1 + $urandom_range(0, 2));
    end
    line_hold(1'b0, 1'b1, 2);
    check_results(1'b0, "rnd2");

    // One-clock glitch at 4 clocks per bit: busy blips, nothing reported.
    b4_seen = 1'b0;
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    repeat (12) @(negedge clk);
    chk("t4_busy_blip", b4_seen, 1'b1);
    check_results(1'b1, "t4_glitch");

    // Randomized frames at 4 clocks per bit.
    for (int k = 0; k < 5; k++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 2) == 0) ? ~good_parity(rd) : good_parity(rd);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(1'b1, rd, rp, rs);
      line_hold(1'b1, 1'b1, 1 + $urandom_range(0, 1));
    end
    line_hold(1'b1, 1'b1, 2);
    check_results(1'b1, "rnd4");

    // Back-to-back frames separated by exactly one idle bit.
    send_frame(1'b0, 8'h00, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 1);
    send_frame(1'b0, 8'hFF, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 3);
    gap = (o2_c.size() == 2) ? (o2_c[1] - o2_c[0]) : -1;
    chk("t5_gap", gap, 12 * 2);
    check_results(1'b0, "t5_b2b");

    // Reset in the middle of data bit 4, then a clean frame.
    rd = 8'h96;
    line_hold(1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) line_hold(1'b0, rd[i], 1);
    rx2 = rd[4];
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_busy", b2, 1'b0);
    chk("t6_rst_valid", v2, 1'b0);
    rx2 = 1'b1;
    rst_n = 1'b1;
    last_d[0] = 8'h00; last_p[0] = 1'b0;
    last_d[1] = 8'h00; last_p[1] = 1'b0;
    line_hold(1'b0, 1'b1, 4);
    check_results(1'b0, "t6_abort");
    send_frame(1'b0, 8'h5A, 1'b1, 1'b1);
    line_hold(1'b0, 1'b1, 3);
    check_results(1'b0, "t6_5a");
    check_results(1'b1, "t6_dut4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the link driven by uart_transmitter.
- Frame, one bit per bit period:
  - start bit (0)
  - 8 data bits, LSB first
  - one parity bit equal to ~(^data[7:0]), i.e. inverted XOR of the 8 data bits
  - stop bit (1)
- Oversamples rx on the system clock, samples each bit at mid-period, and presents the byte with a one-cycle valid pulse plus parity/framing status.

Parameters:
- CLKS_PER_BIT, 2, system clock cycles per bit period. Legal range 2..255; 2 matches clk_uart = clk/2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last received byte.
- data_valid  output  1  one-cycle pulse: data_out holds a newly received byte.
- parity_error  output  1  qualified by data_valid; 1 = received parity != ~(^data_out).
- frame_error  output  1  one-cycle pulse: stop bit sampled 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: on rst_n low, immediately and asynchronously:
  - state=IDLE
  - data_out=8'h00; data_valid=0; parity_error=0; frame_error=0; busy=0
  - sync flops=1; bit counter=0; tick counter=0
- Synchronizer: rx passes through 2 flops → rx_s. All decisions use rx_s. Edge detect compares rx_s with its previous value.
- Tick counter: counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, floor, minimum 1.
- IDLE:
  - busy=0.
  - Falling edge of rx_s (prev 1, now 0) in cycle t0 → START, tick counter cleared.
- START: at t0+HALF sample rx_s.
  - 0 → DATA, bit index=0, tick counter cleared.
  - 1 → glitch: IDLE, no flag, no output change.
- DATA: bit i sampled at t0+HALF+(i+1)*CLKS_PER_BIT into shift register bit i (LSB first). After i=7 → PARITY.
- PARITY: sampled at t0+HALF+9*CLKS_PER_BIT and stored → STOP.
- STOP: sampled at t0+HALF+10*CLKS_PER_BIT.
  - Stop=1: next cycle, data_out<=shift register, data_valid=1 for exactly one cycle, parity_error<=(rx_parity != ~(^shift)). Then → IDLE.
  - Stop=0: next cycle, frame_error=1 for one cycle, data_out and parity_error unchanged, data_valid stays 0. Then → BREAK.
- BREAK: wait until rx_s=1, then → IDLE. A line held low never produces further frames.
- parity_error holds its value until the next data_valid.
- Latency: rx input falling edge → data_valid = 2 (sync) + 1 (edge) + HALF + 10*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: return to IDLE happens the cycle after the stop sample. The stop bit plus ≥1 idle-high bit period guarantees the next falling edge is seen. A start edge arriving in the same cycle as the IDLE transition must be detected.
- busy rises the cycle after the edge is detected; falls on entry to IDLE.
- Reset mid-frame: all state is discarded, no pulse is generated, and the receiver resumes in IDLE, hunting for a fresh falling edge.
- Simultaneous events: data_valid and frame_error are mutually exclusive.

Test Plan:
1. CLKS_PER_BIT=2; send 0xA5, parity=1, stop=1 → one data_valid pulse, data_out=0xA5, parity_error=0, frame_error never high, busy low afterwards.
2. Send 0x01 with parity bit forced to 1 (correct value 0) → data_valid pulse, data_out=0x01, parity_error=1; then send 0x03 with parity=1 → parity_error returns to 0.
3. Send 0x3C with stop bit 0, hold rx low 5 bit periods, then high → frame_error pulses once, no data_valid, data_out keeps its previous value, busy stays high until rx returns high.
4. CLKS_PER_BIT=4; pulse rx low for 1 clk while idle → busy pulses briefly, returns to IDLE; no data_valid or frame_error.
5. Back-to-back 0x00 then 0xFF with one idle bit period between frames → two data_valid pulses, data_out=0x00 then 0xFF, parity_error=0 both times, and the second valid exactly 12*CLKS_PER_BIT cycles after the first.
6. Assert rst_n low during data bit 4 of a frame, release, then send 0x5A → no output from the aborted frame; 0x5A received cleanly with data_valid and parity_error=0.
